cluster_power_sequencer: RTL and testbench

- Sequences clock enable, reset and AXI isolation for the NumClusters external compute clusters.
- Sits between the top-level config registers, which supply per-cluster enable targets, and the per-cluster clock gates, reset lines and AXI isolate blocks.
- One shared FSM serves one cluster transition at a time; pending requests are arbitrated round-robin.
- Detects isolation-acknowledge timeouts on power-down and reports them as sticky per-cluster errors.

---
 rtl/cluster_power_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_cluster_power_sequencer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cluster_power_sequencer.sv
// Power sequencer for the external compute clusters: one shared FSM walks a
// single cluster at a time through clock / reset / isolation phases, with
// round-robin arbitration of pending requests and a sticky iso-ack timeout flag.
module cluster_power_sequencer #(
   parameter int unsigned NumClusters      = 5,
   parameter int unsigned ClkSettleCycles  = 4,
   parameter int unsigned RstHoldCycles    = 8,
   parameter int unsigned IsoTimeoutCycles = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic [NumClusters-1:0] en_req_i,
   input  logic [NumClusters-1:0] iso_ack_i,
   input  logic [NumClusters-1:0] err_clr_i,
   output logic [NumClusters-1:0] cluster_clk_en_o,
   output logic [NumClusters-1:0] cluster_rst_no,
   output logic [NumClusters-1:0] cluster_iso_o,
   output logic [NumClusters-1:0] status_on_o,
   output logic [NumClusters-1:0] err_timeout_o,
   output logic                   busy_o
);

   localparam int unsigned MaxPhase  = (ClkSettleCycles > RstHoldCycles) ? ClkSettleCycles : RstHoldCycles;
   localparam int unsigned MaxCycles = (MaxPhase > IsoTimeoutCycles) ? MaxPhase : IsoTimeoutCycles;
   localparam int unsigned CntWidth  = $clog2(MaxCycles) + 1;
   localparam int unsigned IdxW      = (NumClusters > 1) ? $clog2(NumClusters) : 1;

   localparam logic [CntWidth-1:0] ClkLoad = CntWidth'(ClkSettleCycles - 1);
   localparam logic [CntWidth-1:0] RstLoad = CntWidth'(RstHoldCycles - 1);
   localparam logic [CntWidth-1:0] IsoLoad = CntWidth'(IsoTimeoutCycles - 1);
   localparam logic [IdxW-1:0]     LastIdx = IdxW'(NumClusters - 1);

   typedef enum logic [2:0] {
      Idle,
      PuClk,
      PuRst,
      PuIso,
      PdIso,
      PdRst,
      PdClk
   } stateT;

   stateT                  stateQ, stateD;
   logic [CntWidth-1:0]    cntQ, cntD;
   logic [IdxW-1:0]        grantQ, grantD;
   logic [IdxW-1:0]        ptrQ, ptrD;
   logic [NumClusters-1:0] clkEnQ, clkEnD;
   logic [NumClusters-1:0] rstNQ, rstND;
   logic [NumClusters-1:0] isoQ, isoD;
   logic [NumClusters-1:0] statusQ, statusD;
   logic [NumClusters-1:0] errQ, errD;
   logic                   busyQ, busyD;

   logic [NumClusters-1:0] pending;
   logic                   found;
   logic [IdxW-1:0]        pick;

   assign pending = (en_req_i ^ statusQ) & ~errQ;

   // Round-robin pick: first pending index at or after the pointer, wrapping.
   always_comb begin
      int unsigned pos;
      logic [IdxW-1:0] posIdx;
      found  = 1'b0;
      pick   = '0;
      pos    = 0;
      posIdx = '0;
      for (int unsigned k = 0; k < NumClusters; k++) begin
         pos = 32'(ptrQ) + k;
         if (pos >= NumClusters) begin
            pos = pos - NumClusters;
         end
         posIdx = IdxW'(pos);
         if (!found && pending[posIdx]) begin
            found = 1'b1;
            pick  = posIdx;
         end
      end
   end

   // Next-state and next-output logic; outputs change on the same edge as the
   // state they belong to, so every output is a plain register.
   always_comb begin
      stateD  = stateQ;
      cntD    = cntQ;
      grantD  = grantQ;
      ptrD    = ptrQ;
      clkEnD  = clkEnQ;
      rstND   = rstNQ;
      isoD    = isoQ;
      statusD = statusQ;
      errD    = errQ & ~err_clr_i;

      unique case (stateQ)
         Idle: begin
            if (found) begin
               grantD = pick;
               ptrD   = (pick == LastIdx) ? '0 : pick + 1'b1;
               if (en_req_i[pick]) begin
                  stateD       = PuClk;
                  cntD         = ClkLoad;
                  clkEnD[pick] = 1'b1;
               end else begin
                  stateD     = PdIso;
                  cntD       = IsoLoad;
                  isoD[pick] = 1'b1;
               end
            end
         end
         PuClk: begin
            if (cntQ == '0) begin
               stateD        = PuRst;
               cntD          = RstLoad;
               rstND[grantQ] = 1'b1;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         PuRst: begin
            if (cntQ == '0) begin
               stateD       = PuIso;
               cntD         = '0;
               isoD[grantQ] = 1'b0;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         PuIso: begin
            stateD          = Idle;
            statusD[grantQ] = 1'b1;
         end
         PdIso: begin
            if (iso_ack_i[grantQ]) begin
               stateD        = PdRst;
               cntD          = RstLoad;
               rstND[grantQ] = 1'b0;
            end else if (cntQ == '0) begin
               // Timeout: cluster stays clocked, out of reset and isolated;
               // the set overrides a simultaneous clear.
               stateD       = Idle;
               errD[grantQ] = 1'b1;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         PdRst: begin
            if (cntQ == '0) begin
               stateD         = PdClk;
               cntD           = ClkLoad;
               clkEnD[grantQ] = 1'b0;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         PdClk: begin
            if (cntQ == '0) begin
               stateD          = Idle;
               statusD[grantQ] = 1'b0;
            end else begin
               cntD = cntQ - 1'b1;
            end
         end
         default: begin
            stateD = Idle;
         end
      endcase

      busyD = (stateD != Idle);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         stateQ  <= Idle;
         cntQ    <= '0;
         grantQ  <= '0;
         ptrQ    <= '0;
         clkEnQ  <= '0;
         rstNQ   <= '0;
         isoQ    <= '1;
         statusQ <= '0;
         errQ    <= '0;
         busyQ   <= 1'b0;
      end else begin
         stateQ  <= stateD;
         cntQ    <= cntD;
         grantQ  <= grantD;
         ptrQ    <= ptrD;
         clkEnQ  <= clkEnD;
         rstNQ   <= rstND;
         isoQ    <= isoD;
         statusQ <= statusD;
         errQ    <= errD;
         busyQ   <= busyD;
      end
   end

   assign cluster_clk_en_o = clkEnQ;
   assign cluster_rst_no   = rstNQ;
   assign cluster_iso_o    = isoQ;
   assign status_on_o      = statusQ;
   assign err_timeout_o    = errQ;
   assign busy_o           = busyQ;

endmodule

// File: tb/tb_cluster_power_sequencer.sv
// Scoreboard bench for cluster_power_sequencer: each stimulus step queues the
// output values expected at given cycles; a negedge monitor pops and checks them.
module tb_cluster_power_sequencer;

   localparam int unsigned N = 5;
   localparam int FClk  = 0;
   localparam int FRst  = 1;
   localparam int FIso  = 2;
   localparam int FSt   = 3;
   localparam int FErr  = 4;
   localparam int FBusy = 5;
   localparam logic [N-1:0] All = '1;

   logic         clk = 1'b0;
   logic         rstN;
   logic [N-1:0] enReq, isoAck, errClr;
   logic [N-1:0] clkEn, clusterRstN, iso, statusOn, errTimeout;
   logic         busy;

   cluster_power_sequencer #(
      .NumClusters(5),
      .ClkSettleCycles(4),
      .RstHoldCycles(8),
      .IsoTimeoutCycles(1024)
   ) dut (
      .clk_i(clk),
      .rst_ni(rstN),
      .en_req_i(enReq),
      .iso_ack_i(isoAck),
      .err_clr_i(errClr),
      .cluster_clk_en_o(clkEn),
      .cluster_rst_no(clusterRstN),
      .cluster_iso_o(iso),
      .status_on_o(statusOn),
      .err_timeout_o(errTimeout),
      .busy_o(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int total = 0;
   int bad   = 0;
   int t0    = 0;

   typedef struct {
      int           due;
      int           field;
      logic [N-1:0] mask;
      logic [N-1:0] val;
      string        tag;
   } expT;

   expT sb[$];

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [N-1:0] observe(input int field);
      case (field)
         FClk:    return clkEn;
         FRst:    return clusterRstN;
         FIso:    return iso;
         FSt:     return statusOn;
         FErr:    return errTimeout;
         default: return {{(N-1){1'b0}}, busy};
      endcase
   endfunction

   task automatic expectAt(input int dlt, input int field, input logic [N-1:0] mask,
                           input logic [N-1:0] val, input string tag);
      expT e;
      e.due   = t0 + dlt;
      e.field = field;
      e.mask  = mask;
      e.val   = val;
      e.tag   = tag;
      sb.push_back(e);
   endtask

   task automatic expectBit(input int dlt, input int field, input int idx, input bit v, input string tag);
      logic [N-1:0] m;
      m      = '0;
      m[idx] = 1'b1;
      expectAt(dlt, field, m, v ? m : '0, $sformatf("%s[%0d]", tag, idx));
   endtask

   task automatic expectReset(input int dlt, input string tag);
      expectAt(dlt, FClk,  All, '0, {tag, "Clk"});
      expectAt(dlt, FRst,  All, '0, {tag, "Rst"});
      expectAt(dlt, FIso,  All, '1, {tag, "Iso"});
      expectAt(dlt, FSt,   All, '0, {tag, "St"});
      expectAt(dlt, FErr,  All, '0, {tag, "Err"});
      expectAt(dlt, FBusy, All, '0, {tag, "Busy"});
   endtask

   // Compare every queued expectation that falls due this cycle.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            checkVal($sformatf("%s@%0d", sb[i].tag, cyc),
                     32'(observe(sb[i].field) & sb[i].mask), 32'(sb[i].val));
            sb.delete(i);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tickTo(input int c);
      while (cyc < c) tick(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [N-1:0] v;
      rstN   = 1'b0;
      enReq  = '0;
      isoAck = '0;
      errClr = '0;
      tick(1);
      t0 = cyc;
      expectReset(1, "por");
      tick(3);

      // Single cluster power-up latency
      rstN  = 1'b1;
      enReq = 5'b00001;
      t0    = cyc;
      expectBit(0,  FClk, 0, 0, "pu0Clk");
      expectBit(1,  FClk, 0, 1, "pu0Clk");
      expectBit(4,  FRst, 0, 0, "pu0Rst");
      expectBit(5,  FRst, 0, 1, "pu0Rst");
      expectBit(12, FIso, 0, 1, "pu0Iso");
      expectBit(13, FIso, 0, 0, "pu0Iso");
      expectBit(13, FSt,  0, 0, "pu0St");
      expectBit(14, FSt,  0, 1, "pu0St");
      expectAt(0,  FBusy, All, 5'b00000, "pu0Busy");
      expectAt(1,  FBusy, All, 5'b00001, "pu0Busy");
      expectAt(13, FBusy, All, 5'b00001, "pu0Busy");
      expectAt(14, FBusy, All, 5'b00000, "pu0Busy");
      expectAt(14, FClk, All, 5'b00001, "pu0ClkVec");
      expectAt(14, FRst, All, 5'b00001, "pu0RstVec");
      expectAt(14, FIso, All, 5'b11110, "pu0IsoVec");
      expectAt(14, FErr, All, 5'b00000, "pu0ErrVec");
      tickTo(t0 + 16);

      // Reset, then all clusters requested at once: served 0..4
      rstN  = 1'b0;
      enReq = '0;
      t0    = cyc;
      expectReset(1, "rst2");
      tick(2);
      rstN  = 1'b1;
      enReq = '1;
      t0    = cyc;
      for (int k = 0; k < 5; k++) begin
         v = N'((1 << (k + 1)) - 1);
         expectBit(14 * k,      FClk, k, 0, "allClk");
         expectBit(14 * k + 1,  FClk, k, 1, "allClk");
         expectBit(14 * k + 13, FSt,  k, 0, "allSt");
         expectAt(14 * k + 14, FSt, All, v, "allStVec");
         expectAt(14 * k + 1,  FBusy, All, 5'b00001, "allBusy");
         expectAt(14 * k + 14, FBusy, All, 5'b00000, "allBusy");
      end
      expectAt(72, FBusy, All, 5'b00000, "allBusyEnd");
      tickTo(t0 + 75);

      // Cluster 2 power-down with late isolation ack
      enReq = 5'b11011;
      t0    = cyc;
      expectBit(0,  FIso, 2, 0, "pd2Iso");
      expectBit(1,  FIso, 2, 1, "pd2Iso");
      expectAt(10, FBusy, All, 5'b00001, "pd2Busy");
      expectBit(11, FRst, 2, 1, "pd2Rst");
      expectBit(12, FRst, 2, 0, "pd2Rst");
      expectBit(19, FClk, 2, 1, "pd2Clk");
      expectBit(20, FClk, 2, 0, "pd2Clk");
      expectAt(20, FErr, All, 5'b00000, "pd2Err");
      expectBit(23, FSt, 2, 1, "pd2St");
      expectBit(24, FSt, 2, 0, "pd2St");
      expectAt(24, FSt, All, 5'b11011, "pd2StVec");
      expectAt(24, FBusy, All, 5'b00000, "pd2Busy");
      tick(11);
      isoAck[2] = 1'b1;
      tickTo(t0 + 26);
      isoAck = '0;

      // Cluster 3 power-down without ack: timeout, exclusion, clear, retry
      enReq = 5'b10011;
      t0    = cyc;
      expectBit(1,    FIso, 3, 1, "to3Iso");
      expectBit(1024, FErr, 3, 0, "to3Err");
      expectAt(1024, FBusy, All, 5'b00001, "to3Busy");
      expectBit(1025, FErr, 3, 1, "to3Err");
      expectAt(1025, FBusy, All, 5'b00000, "to3Busy");
      expectAt(1030, FSt, All, 5'b11011, "to3StVec");
      expectBit(1030, FClk, 3, 1, "to3Clk");
      expectBit(1030, FRst, 3, 1, "to3Rst");
      expectBit(1030, FIso, 3, 1, "to3Iso");
      expectAt(1035, FBusy, All, 5'b00000, "to3Excl");
      expectAt(1040, FErr, All, 5'b01000, "to3ErrVec");
      expectBit(1041, FErr, 3, 0, "to3Clr");
      expectAt(1041, FBusy, All, 5'b00000, "to3ClrBusy");
      expectAt(1042, FBusy, All, 5'b00001, "to3Regrant");
      expectBit(1045, FRst, 3, 1, "to3Rst");
      expectBit(1046, FRst, 3, 0, "to3Rst");
      expectBit(1054, FClk, 3, 0, "to3Clk");
      expectAt(1058, FSt, All, 5'b10011, "to3StVec");
      tickTo(t0 + 1040);
      errClr[3] = 1'b1;
      tick(1);
      errClr = '0;
      tickTo(t0 + 1045);
      isoAck[3] = 1'b1;
      tickTo(t0 + 1060);
      isoAck = '0;

      // Power up 2 (pointer -> 3), then pending {1,4}: 4 served before 1;
      // a short pulse on request 3 during the sequence is ignored
      enReq = 5'b10111;
      t0    = cyc;
      expectAt(14, FSt, All, 5'b10111, "rrStVec");
      expectBit(14, FIso, 4, 0, "rr4Iso");
      expectBit(15, FIso, 4, 1, "rr4Iso");
      expectBit(15, FClk, 3, 0, "rr3Clk");
      expectBit(16, FRst, 4, 0, "rr4Rst");
      expectBit(24, FClk, 4, 0, "rr4Clk");
      expectBit(27, FSt,  4, 1, "rr4St");
      expectBit(28, FSt,  4, 0, "rr4St");
      expectBit(28, FIso, 1, 0, "rr1Iso");
      expectBit(29, FIso, 1, 1, "rr1Iso");
      expectBit(30, FRst, 1, 0, "rr1Rst");
      expectBit(41, FSt,  1, 1, "rr1St");
      expectBit(42, FSt,  1, 0, "rr1St");
      expectAt(42, FSt, All, 5'b00101, "rrStEnd");
      expectBit(43, FClk, 3, 0, "rr3Clk");
      expectAt(43, FBusy, All, 5'b00000, "rrBusy");
      tick(2);
      enReq  = 5'b00101;
      isoAck = '1;
      tick(1);
      enReq = 5'b01101;
      tickTo(t0 + 6);
      enReq = 5'b00101;
      tickTo(t0 + 44);

      // Reset in the middle of cluster 1's reset phase
      enReq = 5'b00111;
      t0    = cyc;
      expectBit(1, FClk, 1, 1, "mid1Clk");
      expectBit(5, FRst, 1, 1, "mid1Rst");
      expectAt(7, FBusy, All, 5'b00001, "midBusy");
      expectReset(8, "mid");
      expectAt(10, FClk, All, 5'b00001, "midPtr");
      tickTo(t0 + 7);
      rstN = 1'b0;
      tickTo(t0 + 9);
      rstN  = 1'b1;
      enReq = 5'b00101;
      tickTo(t0 + 14);

      for (int i = 0; i < 5 && sb.size() > 0; i++) tick(1);
      checkVal("sbDrain", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
